// File: rtl/dpram_pkg.sv
// Shared types and limits for the dual-port RAM behavioural model.
package dpram_pkg;

   typedef enum logic {
      READ_FIRST  = 1'b0,
      WRITE_FIRST = 1'b1
   } collision_mode_e;

   localparam int RD_LATENCY_MAX = 8;

endpackage

// File: rtl/rd_resp_pipe.sv
// Fixed-depth shift pipeline carrying read responses; valid and payload
// travel together so responses leave in issue order.
module rd_resp_pipe #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : stage
         logic             valid_reg;
         logic [WIDTH-1:0] data_reg;
         logic             valid_next;
         logic [WIDTH-1:0] data_next;

         if (gi == 0) begin : g_head
            assign valid_next = in_valid;
            assign data_next  = in_data;
         end else begin : g_link
            assign valid_next = stage[gi-1].valid_reg;
            assign data_next  = stage[gi-1].data_reg;
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               valid_reg <= 1'b0;
               data_reg  <= '0;
            end else begin
               valid_reg <= valid_next;
               data_reg  <= data_next;
            end
         end
      end
   endgenerate

   assign out_valid = stage[DEPTH-1].valid_reg;
   assign out_data  = stage[DEPTH-1].data_reg;

endmodule

// File: rtl/dpram_pipe_model.sv
// Byte-writable dual-port RAM model with per-entry valid bits, a pipelined
// read port with error injection, and saturating response counters.
module dpram_pipe_model
   import dpram_pkg::*;
#(
   parameter int              ADDR_WIDTH     = 8,
   parameter int              DATA_WIDTH     = 32,
   parameter int              RD_LATENCY     = 2,
   parameter collision_mode_e COLLISION_MODE = READ_FIRST,
   parameter bit              DELETE_ON_READ = 1'b0,
   localparam int             BE_WIDTH       = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_cs,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [BE_WIDTH-1:0]   wr_be,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_cs,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic                  inj_data_err,
   input  logic                  inj_ecccorr,
   input  logic                  inj_eccderr,
   input  logic                  clear,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_uninit,
   output logic                  ecccorr,
   output logic                  eccderr,
   output logic [15:0]           rd_count,
   output logic [15:0]           uninit_count
);

   localparam int DEPTH      = 2 ** ADDR_WIDTH;
   localparam int PAYLOAD_W  = DATA_WIDTH + 3;
   localparam int PIPE_DEPTH = (RD_LATENCY < 1) ? 1 :
                               (RD_LATENCY > RD_LATENCY_MAX) ? RD_LATENCY_MAX : RD_LATENCY;

   logic                  wr_en;
   logic                  collide;
   logic                  old_valid;
   logic                  hit_valid;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [PAYLOAD_W-1:0]  payload_in;
   logic                  pipe_valid;
   logic [PAYLOAD_W-1:0]  pipe_data;
   logic [DEPTH-1:0]      valid_reg;
   logic [DEPTH-1:0]      valid_next;
   logic [15:0]           rd_count_reg;
   logic [15:0]           rd_count_next;
   logic [15:0]           uninit_count_reg;
   logic [15:0]           uninit_count_next;

   assign wr_en     = wr_cs && (wr_be != '0);
   assign collide   = wr_en && (wr_addr == rd_addr);
   assign old_valid = valid_reg[rd_addr];
   assign hit_valid = old_valid || ((COLLISION_MODE == WRITE_FIRST) && collide);

   // One memory per byte lane. A write to an entry that is invalid (or being
   // cleared) also writes zeros into its disabled lanes, so stale bytes never
   // resurface once the entry becomes valid again.
   genvar gi;
   generate
      for (gi = 0; gi < BE_WIDTH; gi++) begin : lane
         logic [7:0] mem [DEPTH];
         logic       byte_we;
         logic [7:0] byte_wdata;
         logic [7:0] old_byte;

         assign byte_we    = wr_en && (wr_be[gi] || !valid_reg[wr_addr] || clear);
         assign byte_wdata = wr_be[gi] ? wr_data[gi*8 +: 8] : 8'h00;
         assign old_byte   = mem[rd_addr];

         always_ff @(posedge clk) begin
            if (byte_we) begin
               mem[wr_addr] <= byte_wdata;
            end
         end

         assign rd_word[gi*8 +: 8] =
            ((COLLISION_MODE == WRITE_FIRST) && collide && wr_be[gi]) ? wr_data[gi*8 +: 8] :
            old_valid                                                  ? old_byte :
                                                                         8'h00;
      end
   endgenerate

   // Priority: clear, then delete-on-read, then the write, so a same-cycle
   // write always leaves its own entry valid.
   always_comb begin
      valid_next = valid_reg;
      if (clear) begin
         valid_next = '0;
      end
      if (DELETE_ON_READ && rd_cs) begin
         valid_next[rd_addr] = 1'b0;
      end
      if (wr_en) begin
         valid_next[wr_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg <= '0;
      end else begin
         valid_reg <= valid_next;
      end
   end

   assign payload_in = {!hit_valid, inj_ecccorr, inj_eccderr,
                        rd_word ^ {DATA_WIDTH{inj_data_err}}};

   rd_resp_pipe #(
      .DEPTH (PIPE_DEPTH),
      .WIDTH (PAYLOAD_W)
   ) u_rd_resp_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rd_cs),
      .in_data   (payload_in),
      .out_valid (pipe_valid),
      .out_data  (pipe_data)
   );

   assign rd_valid  = pipe_valid;
   assign rd_data   = pipe_valid ? pipe_data[DATA_WIDTH-1:0] : '0;
   assign rd_uninit = pipe_valid & pipe_data[DATA_WIDTH+2];
   assign ecccorr   = pipe_valid & pipe_data[DATA_WIDTH+1];
   assign eccderr   = pipe_valid & pipe_data[DATA_WIDTH];

   always_comb begin
      rd_count_next     = rd_count_reg;
      uninit_count_next = uninit_count_reg;
      if (pipe_valid && (rd_count_reg != 16'hFFFF)) begin
         rd_count_next = rd_count_reg + 16'd1;
      end
      if (pipe_valid && rd_uninit && (uninit_count_reg != 16'hFFFF)) begin
         uninit_count_next = uninit_count_reg + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_count_reg     <= 16'd0;
         uninit_count_reg <= 16'd0;
      end else begin
         rd_count_reg     <= rd_count_next;
         uninit_count_reg <= uninit_count_next;
      end
   end

   assign rd_count     = rd_count_reg;
   assign uninit_count = uninit_count_reg;

endmodule

// File: tb/tb_dpram_pipe_model.sv
// Scoreboard bench: three model instances (READ_FIRST, WRITE_FIRST,
// READ_FIRST with delete-on-read) driven by directed vectors.
module tb_dpram_pipe_model;
   import dpram_pkg::*;

   typedef struct packed {
      logic [31:0] data;
      logic        uninit;
      logic        corr;
      logic        derr;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        wr_cs        [3];
   logic [7:0]  wr_addr      [3];
   logic [3:0]  wr_be        [3];
   logic [31:0] wr_data      [3];
   logic        rd_cs        [3];
   logic [7:0]  rd_addr      [3];
   logic        inj_data_err [3];
   logic        inj_ecccorr  [3];
   logic        inj_eccderr  [3];
   logic        clear        [3];
   logic        rd_valid     [3];
   logic [31:0] rd_data      [3];
   logic        rd_uninit    [3];
   logic        ecccorr      [3];
   logic        eccderr      [3];
   logic [15:0] rd_count     [3];
   logic [15:0] uninit_count [3];

   dpram_pipe_model #(.COLLISION_MODE(READ_FIRST), .DELETE_ON_READ(1'b0)) dut_rf (
      .clk(clk), .rst(rst), .wr_cs(wr_cs[0]), .wr_addr(wr_addr[0]), .wr_be(wr_be[0]),
      .wr_data(wr_data[0]), .rd_cs(rd_cs[0]), .rd_addr(rd_addr[0]),
      .inj_data_err(inj_data_err[0]), .inj_ecccorr(inj_ecccorr[0]), .inj_eccderr(inj_eccderr[0]),
      .clear(clear[0]), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]), .rd_uninit(rd_uninit[0]),
      .ecccorr(ecccorr[0]), .eccderr(eccderr[0]), .rd_count(rd_count[0]),
      .uninit_count(uninit_count[0]));

   dpram_pipe_model #(.COLLISION_MODE(WRITE_FIRST), .DELETE_ON_READ(1'b0)) dut_wf (
      .clk(clk), .rst(rst), .wr_cs(wr_cs[1]), .wr_addr(wr_addr[1]), .wr_be(wr_be[1]),
      .wr_data(wr_data[1]), .rd_cs(rd_cs[1]), .rd_addr(rd_addr[1]),
      .inj_data_err(inj_data_err[1]), .inj_ecccorr(inj_ecccorr[1]), .inj_eccderr(inj_eccderr[1]),
      .clear(clear[1]), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]), .rd_uninit(rd_uninit[1]),
      .ecccorr(ecccorr[1]), .eccderr(eccderr[1]), .rd_count(rd_count[1]),
      .uninit_count(uninit_count[1]));

   dpram_pipe_model #(.COLLISION_MODE(READ_FIRST), .DELETE_ON_READ(1'b1)) dut_dor (
      .clk(clk), .rst(rst), .wr_cs(wr_cs[2]), .wr_addr(wr_addr[2]), .wr_be(wr_be[2]),
      .wr_data(wr_data[2]), .rd_cs(rd_cs[2]), .rd_addr(rd_addr[2]),
      .inj_data_err(inj_data_err[2]), .inj_ecccorr(inj_ecccorr[2]), .inj_eccderr(inj_eccderr[2]),
      .clear(clear[2]), .rd_valid(rd_valid[2]), .rd_data(rd_data[2]), .rd_uninit(rd_uninit[2]),
      .ecccorr(ecccorr[2]), .eccderr(eccderr[2]), .rd_count(rd_count[2]),
      .uninit_count(uninit_count[2]));

   int   checks = 0;
   int   errors = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   function automatic int qsize(int d);
      case (d)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic exp_t qpop(int d);
      case (d)
         0:       return q0.pop_front();
         1:       return q1.pop_front();
         default: return q2.pop_front();
      endcase
   endfunction

   task automatic qpush(int d, exp_t e);
      case (d)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   // Monitor: pops one expectation per response; idle cycles must be all zero.
   always @(negedge clk) begin
      exp_t e;
      exp_t got;
      for (int d = 0; d < 3; d++) begin
         got = {rd_data[d], rd_uninit[d], ecccorr[d], eccderr[d]};
         checks++;
         if (rd_valid[d] === 1'b1) begin
            if (qsize(d) == 0) begin
               errors++;
               $display("FAIL unexpected_rd_valid dut%0d: got data=%h uninit=%0b, required no response",
                        d, rd_data[d], rd_uninit[d]);
            end else begin
               e = qpop(d);
               $display("resp dut%0d data=%h uninit=%0b corr=%0b derr=%0b (exp data=%h uninit=%0b corr=%0b derr=%0b)",
                        d, got.data, got.uninit, got.corr, got.derr, e.data, e.uninit, e.corr, e.derr);
               if (got !== e) begin
                  errors++;
                  $display("FAIL resp dut%0d: got data=%h uninit=%0b corr=%0b derr=%0b, required data=%h uninit=%0b corr=%0b derr=%0b",
                           d, got.data, got.uninit, got.corr, got.derr, e.data, e.uninit, e.corr, e.derr);
               end
            end
         end else if (got !== '0) begin
            errors++;
            $display("FAIL idle_outputs_zero dut%0d: got data=%h uninit=%0b corr=%0b derr=%0b, required all 0",
                     d, got.data, got.uninit, got.corr, got.derr);
         end
      end
   end

   task automatic check16(string name, logic [15:0] act, logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end else begin
         $display("check %s = %0d", name, act);
      end
   endtask

   // One clock of stimulus on instance d; inputs return to idle afterwards.
   task automatic cyc(int d, logic wcs, logic [7:0] wa, logic [3:0] be, logic [31:0] wd,
                      logic rcs, logic [7:0] ra, logic [2:0] inj, logic clr);
      wr_cs[d] = wcs;  wr_addr[d] = wa;  wr_be[d] = be;  wr_data[d] = wd;
      rd_cs[d] = rcs;  rd_addr[d] = ra;  clear[d] = clr;
      {inj_data_err[d], inj_ecccorr[d], inj_eccderr[d]} = inj;
      @(posedge clk);
      #1;
      wr_cs[d] = 1'b0;  rd_cs[d] = 1'b0;  clear[d] = 1'b0;  wr_be[d] = 4'h0;
      {inj_data_err[d], inj_ecccorr[d], inj_eccderr[d]} = 3'b000;
   endtask

   task automatic wr(int d, logic [7:0] a, logic [3:0] be, logic [31:0] dat);
      cyc(d, 1'b1, a, be, dat, 1'b0, 8'h00, 3'b000, 1'b0);
   endtask

   // inj = {data_err, ecccorr, eccderr}
   task automatic rd(int d, logic [7:0] a, logic [2:0] inj, logic [31:0] exp_data, logic exp_uninit);
      qpush(d, {exp_data, exp_uninit, inj[1], inj[0]});
      cyc(d, 1'b0, 8'h00, 4'h0, 32'h0, 1'b1, a, inj, 1'b0);
   endtask

   task automatic wr_rd(int d, logic [7:0] a, logic [3:0] be, logic [31:0] dat,
                        logic [31:0] exp_data, logic exp_uninit);
      qpush(d, {exp_data, exp_uninit, 1'b0, 1'b0});
      cyc(d, 1'b1, a, be, dat, 1'b1, a, 3'b000, 1'b0);
   endtask

   task automatic drain(int d);
      int n = 0;
      while (qsize(d) != 0 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (qsize(d) != 0) begin
         errors++;
         $display("FAIL drain_timeout dut%0d: %0d responses outstanding, required 0", d, qsize(d));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         wr_cs[d] = 0; wr_addr[d] = 0; wr_be[d] = 0; wr_data[d] = 0;
         rd_cs[d] = 0; rd_addr[d] = 0; clear[d] = 0;
         inj_data_err[d] = 0; inj_ecccorr[d] = 0; inj_eccderr[d] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int d = 0; d < 3; d++) begin
         check16($sformatf("reset_rd_count_dut%0d", d), rd_count[d], 16'd0);
         check16($sformatf("reset_uninit_count_dut%0d", d), uninit_count[d], 16'd0);
      end

      // READ_FIRST instance: basic write/read with latency check
      wr(0, 8'h10, 4'hF, 32'hDEADBEEF);
      rd(0, 8'h10, 3'b000, 32'hDEADBEEF, 1'b0);
      check16("latency_rd_valid_cycle1", {15'd0, rd_valid[0]}, 16'd0);
      @(posedge clk); #1;
      check16("latency_rd_valid_cycle2", {15'd0, rd_valid[0]}, 16'd1);
      @(posedge clk); #1;
      check16("latency_rd_valid_one_cycle", {15'd0, rd_valid[0]}, 16'd0);
      drain(0);
      check16("rf_rd_count_after_first", rd_count[0], 16'd1);
      check16("rf_uninit_count_after_first", uninit_count[0], 16'd0);

      wr(0, 8'h05, 4'hF, 32'h11223344);
      wr(0, 8'h05, 4'b0010, 32'hAABBCCDD);
      rd(0, 8'h05, 3'b000, 32'h1122CC44, 1'b0);
      wr(0, 8'h40, 4'b0001, 32'hAABBCCDD);
      rd(0, 8'h40, 3'b000, 32'h000000DD, 1'b0);
      wr(0, 8'h41, 4'h0, 32'h12345678);
      rd(0, 8'h41, 3'b000, 32'h00000000, 1'b1);
      wr(0, 8'h07, 4'hF, 32'h00000000);
      wr_rd(0, 8'h07, 4'hF, 32'h00000001, 32'h00000000, 1'b0);
      rd(0, 8'h07, 3'b000, 32'h00000001, 1'b0);
      rd(0, 8'h10, 3'b111, 32'h21524110, 1'b0);
      drain(0);

      // WRITE_FIRST instance
      rd(1, 8'h22, 3'b000, 32'h00000000, 1'b1);
      drain(1);
      check16("wf_rd_count_uninit_read", rd_count[1], 16'd1);
      check16("wf_uninit_count_uninit_read", uninit_count[1], 16'd1);
      rd(1, 8'h22, 3'b100, 32'hFFFFFFFF, 1'b1);
      drain(1);
      check16("wf_rd_count_inverted_uninit", rd_count[1], 16'd2);
      check16("wf_uninit_count_inverted_uninit", uninit_count[1], 16'd2);
      wr(1, 8'h07, 4'hF, 32'h00000000);
      wr_rd(1, 8'h07, 4'hF, 32'h00000001, 32'h00000001, 1'b0);
      rd(1, 8'h07, 3'b100, 32'hFFFFFFFE, 1'b0);
      wr_rd(1, 8'h50, 4'b0100, 32'h12345678, 32'h00340000, 1'b0);
      rd(1, 8'h50, 3'b000, 32'h00340000, 1'b0);
      drain(1);

      // Delete-on-read instance
      wr(2, 8'h30, 4'hF, 32'hCAFEF00D);
      rd(2, 8'h30, 3'b000, 32'hCAFEF00D, 1'b0);
      rd(2, 8'h30, 3'b000, 32'h00000000, 1'b1);
      wr(2, 8'h31, 4'hF, 32'h00000001);
      wr(2, 8'h32, 4'hF, 32'h00000002);
      cyc(2, 1'b1, 8'h31, 4'hF, 32'h00000055, 1'b0, 8'h00, 3'b000, 1'b1);
      rd(2, 8'h31, 3'b000, 32'h00000055, 1'b0);
      rd(2, 8'h32, 3'b000, 32'h00000000, 1'b1);
      wr_rd(2, 8'h33, 4'hF, 32'h00000077, 32'h00000000, 1'b1);
      rd(2, 8'h33, 3'b000, 32'h00000077, 1'b0);
      drain(2);
      check16("dor_rd_count", rd_count[2], 16'd6);
      check16("dor_uninit_count", uninit_count[2], 16'd3);

      // Back-to-back reads with injection, reset while the last is in flight
      rd(0, 8'h10, 3'b000, 32'hDEADBEEF, 1'b0);
      rd(0, 8'h10, 3'b010, 32'hDEADBEEF, 1'b0);
      rd(0, 8'h05, 3'b001, 32'h1122CC44, 1'b0);
      cyc(0, 1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 8'h07, 3'b000, 1'b0);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check16("reset_async_rd_count", rd_count[0], 16'd0);
      check16("reset_async_rd_valid", {15'd0, rd_valid[0]}, 16'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check16("reset_pending_expectations", qsize(0), 16'd0);
      check16("post_reset_rd_count", rd_count[0], 16'd0);
      rd(0, 8'h10, 3'b000, 32'h00000000, 1'b1);
      drain(0);
      check16("post_reset_rd_count_one", rd_count[0], 16'd1);
      check16("post_reset_uninit_count_one", uninit_count[0], 16'd1);

      repeat (4) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
